// File: rtl/pe_driver.sv
// Initiator-side sequencer for one matrix-multiplier PE: takes a row/column job,
// loads the row, pulses start, streams the column, and returns the PE total.
module pe_driver #(
  parameter int P           = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int ACCUM_WIDTH = 2*DATA_WIDTH,
  parameter int TIMEOUT     = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            job_valid,
  output logic                            job_ready,
  input  logic [P-1:0][DATA_WIDTH-1:0]    job_row,
  input  logic [P-1:0][DATA_WIDTH-1:0]    job_col,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [ACCUM_WIDTH-1:0]          res_total,
  output logic                            res_err,
  output logic                            res_timeout,
  output logic                            pe_load_row,
  output logic                            pe_start,
  output logic [P-1:0][DATA_WIDTH-1:0]    pe_row,
  output logic [DATA_WIDTH-1:0]           pe_col_entry,
  input  logic                            pe_done,
  input  logic                            pe_err,
  input  logic [ACCUM_WIDTH-1:0]          pe_total
);

  localparam int KW = (P > 1) ? $clog2(P) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [KW-1:0] K_LAST   = KW'(P - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_STREAM = 3'd3,
    S_WAIT   = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t                         state_r;
  logic [P-1:0][DATA_WIDTH-1:0]   row_r;
  logic [P-1:0][DATA_WIDTH-1:0]   col_r;
  logic [KW-1:0]                  k_r;
  logic [TW-1:0]                  tmo_r;
  logic                           job_ready_r;
  logic                           res_valid_r;
  logic [ACCUM_WIDTH-1:0]         res_total_r;
  logic                           res_err_r;
  logic                           res_timeout_r;
  logic                           pe_load_row_r;
  logic                           pe_start_r;

  // Sequencer FSM; strobes are set on the transition into the state they belong to,
  // so every output is a flop and a strobe cannot glitch out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      row_r         <= '0;
      col_r         <= '0;
      k_r           <= '0;
      tmo_r         <= '0;
      job_ready_r   <= 1'b0;
      res_valid_r   <= 1'b0;
      res_total_r   <= '0;
      res_err_r     <= 1'b0;
      res_timeout_r <= 1'b0;
      pe_load_row_r <= 1'b0;
      pe_start_r    <= 1'b0;
    end else begin
      pe_load_row_r <= 1'b0;
      pe_start_r    <= 1'b0;
      case (state_r)
        S_IDLE: begin
          job_ready_r <= 1'b1;
          if (job_valid && job_ready_r) begin
            row_r         <= job_row;
            col_r         <= job_col;
            k_r           <= '0;
            job_ready_r   <= 1'b0;
            pe_load_row_r <= 1'b1;
            state_r       <= S_LOAD;
          end
        end
        S_LOAD: begin
          pe_start_r <= 1'b1;
          state_r    <= S_START;
        end
        S_START: begin
          k_r     <= '0;
          state_r <= S_STREAM;
        end
        S_STREAM: begin
          if (k_r == K_LAST) begin
            tmo_r   <= '0;
            state_r <= S_WAIT;
          end else begin
            k_r <= k_r + KW'(1);
          end
        end
        S_WAIT: begin
          tmo_r <= tmo_r + TW'(1);
          // done has priority over a timeout expiring in the same cycle
          if (pe_done) begin
            res_total_r   <= pe_total;
            res_err_r     <= pe_err;
            res_timeout_r <= 1'b0;
            res_valid_r   <= 1'b1;
            state_r       <= S_RESP;
          end else if (tmo_r == TMO_LAST) begin
            res_total_r   <= '0;
            res_err_r     <= 1'b0;
            res_timeout_r <= 1'b1;
            res_valid_r   <= 1'b1;
            state_r       <= S_RESP;
          end
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            job_ready_r <= 1'b1;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          job_ready_r <= 1'b0;
          res_valid_r <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign job_ready    = job_ready_r;
  assign res_valid    = res_valid_r;
  assign res_total    = res_total_r;
  assign res_err      = res_err_r;
  assign res_timeout  = res_timeout_r;
  assign pe_load_row  = pe_load_row_r;
  assign pe_start     = pe_start_r;
  assign pe_row       = row_r;
  assign pe_col_entry = col_r[k_r];

endmodule

// File: tb/tb_pe_driver.sv
// Self-checking bench for pe_driver: behavioural PE responder plus a dot-product
// reference computed directly from each job, with random and directed jobs.
module tb_pe_driver;

  localparam int P   = 4;
  localparam int DW  = 16;
  localparam int AW  = 32;
  localparam int TMO = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   job_valid = 1'b0;
  logic                   job_ready;
  logic [P-1:0][DW-1:0]   job_row = '0;
  logic [P-1:0][DW-1:0]   job_col = '0;
  logic                   res_valid;
  logic                   res_ready = 1'b0;
  logic [AW-1:0]          res_total;
  logic                   res_err;
  logic                   res_timeout;
  logic                   pe_load_row;
  logic                   pe_start;
  logic [P-1:0][DW-1:0]   pe_row;
  logic [DW-1:0]          pe_col_entry;
  logic                   pe_done;
  logic                   pe_err;
  logic [AW-1:0]          pe_total;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_load = 0;
  int start_q[$];
  logic [AW+1:0] res_q[$];

  bit never_done = 1'b0;
  bit err_mode   = 1'b0;

  pe_driver #(.P(P), .DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_row(job_row), .job_col(job_col),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_total(res_total), .res_err(res_err), .res_timeout(res_timeout),
    .pe_load_row(pe_load_row), .pe_start(pe_start),
    .pe_row(pe_row), .pe_col_entry(pe_col_entry),
    .pe_done(pe_done), .pe_err(pe_err), .pe_total(pe_total)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Ideal PE: latch row on load, clear on start, MAC the next P streamed entries,
  // raise done one cycle after the last product.
  logic [P-1:0][DW-1:0] pe_row_lat;
  int  pe_cnt;
  bit  pe_active;
  int  pe_acc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_done <= 1'b0; pe_err <= 1'b0; pe_total <= '0;
      pe_active <= 1'b0; pe_cnt <= 0; pe_acc <= 0; pe_row_lat <= '0;
    end else begin
      if (pe_load_row) pe_row_lat <= pe_row;
      if (pe_start) begin
        pe_done <= 1'b0; pe_err <= 1'b0; pe_acc <= 0; pe_cnt <= 0; pe_active <= 1'b1;
      end else if (pe_active) begin
        if (pe_cnt < P) begin
          pe_acc <= pe_acc + int'(signed'(pe_row_lat[pe_cnt])) * int'(signed'(pe_col_entry));
          pe_cnt <= pe_cnt + 1;
        end else begin
          pe_active <= 1'b0;
          if (!never_done) begin
            pe_done  <= 1'b1;
            pe_total <= pe_acc;
            pe_err   <= err_mode;
          end
        end
      end
    end
  end

  // Event monitor: start pulse times, load pulse count, completed result handshakes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pe_start) start_q.push_back(cyc);
      if (pe_load_row) n_load++;
      if (res_valid && res_ready) res_q.push_back({res_timeout, res_err, res_total});
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] dot(input logic [P-1:0][DW-1:0] r, input logic [P-1:0][DW-1:0] c);
    int s = 0;
    for (int i = 0; i < P; i++) s += int'(signed'(r[i])) * int'(signed'(c[i]));
    return AW'(s);
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (!job_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("job_ready_wait", job_ready, 1);
  endtask

  task automatic run_job(input logic [P-1:0][DW-1:0] row, input logic [P-1:0][DW-1:0] col,
                         input bit nd, input bit em, input int hold);
    logic [AW-1:0] exp_total;
    int first = 0;
    exp_total = nd ? '0 : dot(row, col);
    never_done = nd;
    err_mode = em;
    @(negedge clk);
    job_row = row; job_col = col; job_valid = 1'b1; res_ready = 1'b0;
    wait_ready();
    @(posedge clk);
    for (int n = 1; n <= P + TMO + 6 && first == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        job_valid = 1'b0;
        chk("load_pulse", pe_load_row, 1);
        chk("start_early", pe_start, 0);
        chk("pe_row", pe_row, row);
      end
      if (n == 2) begin
        chk("start_pulse", pe_start, 1);
        chk("load_late", pe_load_row, 0);
      end
      if (n >= 3 && n <= P + 2) chk("col_stream", pe_col_entry, col[n-3]);
      else if (n > P + 2 && !res_valid) chk("col_hold", pe_col_entry, col[P-1]);
      if (n > 2) chk("no_strobe", {pe_load_row, pe_start}, 0);
      if (res_valid) first = n;
    end
    chk("latency", first, nd ? (P + 3 + TMO) : (P + 5));
    chk("res_total", res_total, exp_total);
    chk("res_err", res_err, (!nd && em) ? 1 : 0);
    chk("res_timeout", res_timeout, nd ? 1 : 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("bp_valid", res_valid, 1);
      chk("bp_total", res_total, exp_total);
      chk("bp_job_ready", job_ready, 0);
      chk("bp_no_start", pe_start, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("valid_drop", res_valid, 0);
    chk("ready_back", job_ready, 1);
  endtask

  task automatic accept_job(input logic [P-1:0][DW-1:0] row, input logic [P-1:0][DW-1:0] col);
    job_row = row; job_col = col; job_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_job_ready"}, job_ready, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_total"}, res_total, 0);
    chk({tag, "_res_err"}, res_err, 0);
    chk({tag, "_res_timeout"}, res_timeout, 0);
    chk({tag, "_load"}, pe_load_row, 0);
    chk({tag, "_start"}, pe_start, 0);
    chk({tag, "_pe_row"}, pe_row, 0);
    chk({tag, "_col_entry"}, pe_col_entry, 0);
  endtask

  function automatic logic [P-1:0][DW-1:0] mk(input int a, input int b, input int c, input int d);
    logic [P-1:0][DW-1:0] v;
    v[0] = DW'(a); v[1] = DW'(b); v[2] = DW'(c); v[3] = DW'(d);
    return v;
  endfunction

  initial begin
    logic [P-1:0][DW-1:0] ra, ca, rb, cb;
    logic [AW+1:0] r;
    int s0, q0, l0, w;

    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", job_ready, 1);

    // directed jobs
    run_job(mk(1, 2, 3, 4), mk(5, 6, 7, 8), 1'b0, 1'b0, 0);
    chk("basic_total", res_q[res_q.size()-1][AW-1:0], 70);
    run_job(mk(-1, -2, 3, -4), mk(7, -3, 2, -5), 1'b0, 1'b0, 0);
    chk("signed_total", res_q[res_q.size()-1][AW-1:0], 25);
    run_job(mk(9, -8, 7, 100), mk(3, 3, -3, 50), 1'b0, 1'b0, 10);
    run_job(mk(1, 1, 1, 1), mk(1, 1, 1, 1), 1'b1, 1'b0, 2);
    run_job(mk(-32768, 32767, -32768, 1), mk(-32768, 32767, 32767, -1), 1'b0, 1'b1, 1);

    // back-to-back with res_ready held high
    never_done = 1'b0; err_mode = 1'b0;
    ra = mk(2, 4, 6, 8); ca = mk(1, -1, 1, -1);
    rb = mk(-5, 0, 5, 10); cb = mk(3, 9, -2, 4);
    s0 = start_q.size(); q0 = res_q.size();
    res_ready = 1'b1;
    @(negedge clk);
    accept_job(ra, ca);
    accept_job(rb, cb);
    w = 0;
    while ((start_q.size() < s0 + 2 || res_q.size() < q0 + 2) && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("b2b_done_wait", (start_q.size() >= s0 + 2 && res_q.size() >= q0 + 2) ? 1 : 0, 1);
    if (start_q.size() >= s0 + 2) chk("b2b_start_gap", start_q[s0+1] - start_q[s0], P + 6);
    if (res_q.size() >= q0 + 2) begin
      r = res_q[q0];
      chk("b2b_total_a", r, {2'b00, dot(ra, ca)});
      r = res_q[q0+1];
      chk("b2b_total_b", r, {2'b00, dot(rb, cb)});
    end
    res_ready = 1'b0;

    // reset in STREAM with k=2
    @(negedge clk);
    job_row = mk(11, 12, 13, 14); job_col = mk(1, 2, 3, 4); job_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) job_valid = 1'b0;
    end
    chk("pre_reset_k2", pe_col_entry, 3);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (2) @(negedge clk);
    chk("in_reset_ready", job_ready, 0);
    rst_n = 1'b1;
    s0 = start_q.size(); l0 = n_load;
    run_job(mk(3, -1, 4, -1), mk(5, 9, -2, 6), 1'b0, 1'b0, 0);
    chk("post_rst_starts", start_q.size() - s0, 1);
    chk("post_rst_loads", n_load - l0, 1);

    // random jobs
    for (int j = 0; j < 20; j++) begin
      logic [P-1:0][DW-1:0] rr, cc;
      for (int i = 0; i < P; i++) begin
        rr[i] = DW'($urandom);
        cc[i] = DW'($urandom);
      end
      run_job(rr, cc, ($urandom_range(5) == 0), ($urandom_range(3) == 0), int'($urandom_range(4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
